multicycle_control_fsm: RTL and testbench

//  Moore sequencer for the multicycle MIPS datapath. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.

---
 rtl/mips_mc_pkg.sv | 86 ++++++++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer:
// state enum, opcode/funct values and datapath select codes.
package mips_mc_pkg;

    // j/jal and beq/bne each share a state; the held IR opcode picks the variant.
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_SH,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_LW,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [2:0] ALU_SUB   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    function automatic logic is_alu_funct(input logic [5:0] f);
        return f inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
                         FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; saturates at TIMEOUT_CYCLES-1,
// where o_expired is raised.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle MIPS datapath with
// memory handshake, wait timeout and illegal-instruction trap.
module multicycle_control_fsm
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_eq,
    output logic       pc_write_ne,
    output logic [1:0] pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_trap_cause;
    logic [1:0] w_cause_next;
    logic       w_expired;
    logic       w_tmr_clr;
    logic       w_tmr_en;
    logic       w_is_r;

    assign w_is_r    = (op == OP_RTYPE);
    assign w_tmr_en  = mem_req && !mem_ready;
    assign w_tmr_clr = !reset || (w_state_next != r_state);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .i_clear  (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state      <= w_state_next;
            r_trap_cause <= w_cause_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_trap_cause;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_state_next = S_DECODE;
                end else if (w_expired) begin
                    w_state_next = S_TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_is_r && (funct == FN_SLL || funct == FN_SRL):
                        w_state_next = S_EXEC_SH;
                    w_is_r && (funct == FN_JR):
                        w_state_next = S_JR;
                    w_is_r && is_alu_funct(funct):
                        w_state_next = S_EXEC_R;
                    op == OP_ADDI || op == OP_ORI || op == OP_LUI:
                        w_state_next = S_EXEC_I;
                    op == OP_LW || op == OP_SW:
                        w_state_next = S_MEM_ADDR;
                    op == OP_BEQ || op == OP_BNE:
                        w_state_next = S_BRANCH;
                    op == OP_J || op == OP_JAL:
                        w_state_next = S_JUMP;
                    default: begin
                        w_state_next = S_TRAP;
                        w_cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_SH: w_state_next = S_WB_R;
            S_EXEC_I:            w_state_next = S_WB_I;
            S_MEM_ADDR: begin
                w_state_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_state_next = S_WB_LW;
                end else if (w_expired) begin
                    w_state_next = S_TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                end else if (w_expired) begin
                    w_state_next = S_TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_WB_R, S_WB_I, S_WB_LW,
            S_BRANCH, S_JUMP, S_JR: w_state_next = S_FETCH;
            S_TRAP:                 w_state_next = S_TRAP;
            default:                w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_write_eq = 1'b0;
        pc_write_ne = 1'b0;
        pc_source   = PC_ALU;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RT;
        alu_op      = ALU_SUB;
        reg_dst     = DST_RT;
        mem_to_reg  = M2R_ALU;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        trap        = 1'b0;
        trap_cause  = CAUSE_NONE;
        if (reset) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    alu_op    = ALU_ADD;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS;
                    alu_op    = ALU_RTYPE;
                end
                S_EXEC_SH: begin
                    alu_src_a = SRCA_SHAMT;
                    alu_op    = ALU_RTYPE;
                end
                S_WB_R: begin
                    reg_dst    = DST_RD;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_IMM;
                    alu_op    = (op == OP_ORI) ? ALU_OR :
                                (op == OP_LUI) ? ALU_LUI : ALU_ADD;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_WB_LW: begin
                    mem_to_reg = M2R_MDR;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req    = 1'b1;
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a   = SRCA_RS;
                    pc_source   = PC_ALUOUT;
                    pc_write_eq = (op == OP_BEQ);
                    pc_write_ne = (op == OP_BNE);
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PC_JUMP;
                    instr_done = 1'b1;
                    if (op == OP_JAL) begin
                        reg_dst    = DST_RA;
                        mem_to_reg = M2R_PC;
                        reg_write  = 1'b1;
                    end
                end
                S_JR: begin
                    pc_write   = 1'b1;
                    pc_source  = PC_RS;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = r_trap_cause;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle output vectors
// compared against hand-derived expectations.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
    logic       pc_write_eq, pc_write_ne, reg_write, instr_done, trap;
    logic [1:0] pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
    logic [1:0] trap_cause;
    logic [2:0] alu_op;
    logic [24:0] w_obs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_write_eq(pc_write_eq),
        .pc_write_ne(pc_write_ne),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    assign w_obs = {mem_req, mem_write, i_or_d, ir_write, pc_write,
                    pc_write_eq, pc_write_ne, pc_source, alu_src_a,
                    alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                    instr_done, trap, trap_cause};

    function automatic logic [24:0] pk(
        input int req, input int wr, input int iod, input int irw,
        input int pcw, input int peq, input int pne, input int psrc,
        input int sa, input int sb, input int aop, input int rd,
        input int m2r, input int rw, input int done, input int trp,
        input int cause);
        return {1'(req), 1'(wr), 1'(iod), 1'(irw), 1'(pcw), 1'(peq),
                1'(pne), 2'(psrc), 2'(sa), 2'(sb), 3'(aop), 2'(rd),
                2'(m2r), 1'(rw), 1'(done), 1'(trp), 2'(cause)};
    endfunction

    //                                req wr iod irw pcw peq pne ps sa sb aop rd m2r rw dn tr c
    localparam logic [24:0] E_ZERO = '0;
    localparam logic [24:0] E_FW   = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_FR   = pk(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_DEC  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_EXIA = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_EXIO = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_EXIL = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 6, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_WBI  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    localparam logic [24:0] E_MA   = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_MRD  = pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_WBLW = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    localparam logic [24:0] E_EXSH = pk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 7, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_EXR  = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_WBR  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    localparam logic [24:0] E_JR   = pk(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [24:0] E_BEQ  = pk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [24:0] E_BNE  = pk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [24:0] E_J    = pk(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [24:0] E_JAL  = pk(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 2, 2, 1, 1, 0, 0);
    localparam logic [24:0] E_MWW  = pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [24:0] E_MWD  = pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [24:0] E_TRP1 = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    localparam logic [24:0] E_TRP2 = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

    task automatic chk(input string tag, input logic [24:0] exp);
        #1;
        n_cmp++;
        assert (w_obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [24:0] exp);
        chk(tag, exp);
        nxt();
    endtask

    initial begin
        reset     = 1'b0;
        op        = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b0;
        nxt();
        nxt();
        mem_ready = 1'b1;
        chk("reset_outputs", E_ZERO);

        reset = 1'b1;
        op    = 6'h08;
        step("addi_fetch", E_FR);
        step("addi_decode", E_DEC);
        step("addi_exec", E_EXIA);
        step("addi_wb", E_WBI);

        op = 6'h23;
        step("lw_fetch", E_FR);
        step("lw_decode", E_DEC);
        step("lw_addr", E_MA);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_rd_wait", E_MRD);
        mem_ready = 1'b1;
        step("lw_rd_done", E_MRD);
        step("lw_wb", E_WBLW);

        op    = 6'h00;
        funct = 6'h00;
        step("sll_fetch", E_FR);
        step("sll_decode", E_DEC);
        step("sll_exec", E_EXSH);
        step("sll_wb", E_WBR);
        funct = 6'h08;
        step("jr_fetch", E_FR);
        step("jr_decode", E_DEC);
        step("jr_exec", E_JR);

        op = 6'h04;
        step("beq_fetch", E_FR);
        step("beq_decode", E_DEC);
        step("beq_exec", E_BEQ);
        op = 6'h05;
        step("bne_fetch", E_FR);
        step("bne_decode", E_DEC);
        step("bne_exec", E_BNE);
        op = 6'h03;
        step("jal_fetch", E_FR);
        step("jal_decode", E_DEC);
        step("jal_exec", E_JAL);
        op = 6'h02;
        step("j_fetch", E_FR);
        step("j_decode", E_DEC);
        step("j_exec", E_J);

        op = 6'h0d;
        step("ori_fetch", E_FR);
        step("ori_decode", E_DEC);
        step("ori_exec", E_EXIO);
        step("ori_wb", E_WBI);
        op = 6'h0f;
        step("lui_fetch", E_FR);
        step("lui_decode", E_DEC);
        step("lui_exec", E_EXIL);
        step("lui_wb", E_WBI);
        op    = 6'h00;
        funct = 6'h20;
        step("add_fetch", E_FR);
        step("add_decode", E_DEC);
        step("add_exec", E_EXR);
        step("add_wb", E_WBR);

        op = 6'h2b;
        step("sw_fetch", E_FR);
        step("sw_decode", E_DEC);
        step("sw_addr", E_MA);
        step("sw_wr_done", E_MWD);

        step("sw2_fetch", E_FR);
        step("sw2_decode", E_DEC);
        step("sw2_addr", E_MA);
        mem_ready = 1'b0;
        chk("sw2_wr_wait", E_MWW);
        reset = 1'b0;
        chk("sw2_reset_mid_wr", E_ZERO);
        nxt();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) step("tmo_wait", E_FW);
        mem_ready = 1'b1;
        op        = 6'h02;
        step("tmo_ready_wins", E_FR);
        step("tmo_win_decode", E_DEC);
        step("tmo_win_jump", E_J);

        op = 6'h3f;
        step("ill_fetch", E_FR);
        step("ill_decode", E_DEC);
        for (int i = 0; i < 20; i++) step("ill_trap_hold", E_TRP1);
        reset = 1'b0;
        step("ill_reset", E_ZERO);
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h01;
        step("illfn_fetch", E_FR);
        step("illfn_decode", E_DEC);
        step("illfn_trap", E_TRP1);

        reset = 1'b0;
        step("tmo_reset", E_ZERO);
        reset     = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step("tmo_fetch_wait", E_FW);
        step("tmo_trap", E_TRP2);
        mem_ready = 1'b1;
        step("tmo_trap_sticky", E_TRP2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
